// File: rtl/alu_exec_pkg.sv
// Shared types for the ALU execute stage: ALU control codes, buffer FSM states, flag and buffer-entry layouts.
// Optional feature macro used by the stage: ALU_EXEC_ILLEGAL_TRAP_EN.
package alu_exec_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0111;
  localparam logic [3:0] ALU_ORR = 4'b1000;
  localparam logic [3:0] ALU_XOR = 4'b1001;
  localparam logic [3:0] ALU_MOV = 4'b1010;
  localparam logic [3:0] ALU_MVN = 4'b1011;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

  // Field order matches the architectural {N,Z,C,V} nibble.
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  // The result field is sized by the stage's WIDTH parameter, so a buffer
  // entry is this metadata wrapped together with the result in the top.
  typedef struct packed {
    logic [3:0] rd;
    logic       wb_en;
  } buf_meta_t;

  function automatic logic alu_code_legal(input logic [3:0] code);
    return (code == ALU_ADD) || (code == ALU_SUB) || (code == ALU_AND) ||
           (code == ALU_ORR) || (code == ALU_XOR) || (code == ALU_MOV) ||
           (code == ALU_MVN);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result, next NZCV and a legal bit for one ALU control code.
// C/V pass through from the current register for logic/move ops.
module alu_core
  import alu_exec_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             v_in,
  output logic [WIDTH-1:0] result,
  output flags_t           flags_nxt,
  output logic             legal
);

  logic [WIDTH:0] add_ext;
  logic [WIDTH:0] sub_ext;
  logic           c_nxt;
  logic           v_nxt;

  assign add_ext = {1'b0, a} + {1'b0, b};
  // A + ~B + 1: the carry out is the ARM "not borrow" sense of C.
  assign sub_ext = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    result = '0;
    c_nxt  = c_in;
    v_nxt  = v_in;
    unique case (alu_ctrl)
      ALU_ADD: begin
        result = add_ext[WIDTH-1:0];
        c_nxt  = add_ext[WIDTH];
        v_nxt  = (a[WIDTH-1] == b[WIDTH-1]) && (add_ext[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        result = sub_ext[WIDTH-1:0];
        c_nxt  = sub_ext[WIDTH];
        v_nxt  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_ext[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: result = a & b;
      ALU_ORR: result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_MOV: result = b;
      ALU_MVN: result = ~b;
      default: result = '0;
    endcase
  end

  assign legal       = alu_code_legal(alu_ctrl);
  assign flags_nxt.n = result[WIDTH-1];
  assign flags_nxt.z = (result == '0);
  assign flags_nxt.c = c_nxt;
  assign flags_nxt.v = v_nxt;

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execute stage: handshake in, NZCV register, 2-entry (output + skid) result buffer to writeback.
// Optional ALU_EXEC_ILLEGAL_TRAP_EN adds a sticky illegal_op output that stops further accepts.
module alu_exec_stage
  import alu_exec_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_alu_ctrl,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_set_flags,
  input  logic             in_no_wb,
  input  logic [3:0]       in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_rd,
  output logic             out_wb_en,
  output logic [3:0]       flags
`ifdef ALU_EXEC_ILLEGAL_TRAP_EN
  ,
  output logic             illegal_op
`endif
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    buf_meta_t        meta;
  } buf_entry_t;

  buf_state_e       state_q, state_d;
  buf_entry_t       out_q, out_d;
  buf_entry_t       skid_q, skid_d;
  flags_t           flags_q, flags_d;
  buf_entry_t       new_entry;
  logic [WIDTH-1:0] core_result;
  flags_t           core_flags;
  logic             core_legal;
  logic             accept;
  logic             drain;
  logic             trap_block;

  alu_core #(.WIDTH(WIDTH)) u_alu_core (
    .alu_ctrl  (in_alu_ctrl),
    .a         (in_a),
    .b         (in_b),
    .c_in      (flags_q.c),
    .v_in      (flags_q.v),
    .result    (core_result),
    .flags_nxt (core_flags),
    .legal     (core_legal)
  );

`ifdef ALU_EXEC_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  assign illegal_d  = illegal_q | (accept & ~core_legal);
  assign trap_block = illegal_q;
  assign illegal_op = illegal_q;

  always_ff @(posedge clk) begin
    if (rst) illegal_q <= 1'b0;
    else     illegal_q <= illegal_d;
  end
`else
  assign trap_block = 1'b0;
`endif

  // Ready depends only on registered state (rst gating keeps it low during reset).
  assign in_ready  = (state_q != TWO) & ~trap_block & ~rst;
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  assign new_entry.result     = core_result;
  assign new_entry.meta.rd    = in_rd;
  assign new_entry.meta.wb_en = ~in_no_wb & core_legal;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    flags_d = flags_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          out_d   = new_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && drain) begin
          out_d = new_entry;
        end else if (accept) begin
          skid_d  = new_entry;
          state_d = TWO;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (drain) begin
          out_d   = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (accept && in_set_flags && core_legal) flags_d = core_flags;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      flags_q <= flags_d;
    end
  end

  assign out_result = out_q.result;
  assign out_rd     = out_q.meta.rd;
  assign out_wb_en  = out_q.meta.wb_en;
  assign flags      = flags_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: flags, buffer ordering/backpressure, illegal codes and reset.
module tb_alu_exec_stage;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_alu_ctrl;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_set_flags;
  logic          in_no_wb;
  logic [3:0]    in_rd;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic [3:0]    out_rd;
  logic          out_wb_en;
  logic [3:0]    flags;
`ifdef ALU_EXEC_ILLEGAL_TRAP_EN
  logic          illegal_op;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_exec_stage #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_alu_ctrl  (in_alu_ctrl),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_set_flags (in_set_flags),
    .in_no_wb     (in_no_wb),
    .in_rd        (in_rd),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_rd       (out_rd),
    .out_wb_en    (out_wb_en),
    .flags        (flags)
`ifdef ALU_EXEC_ILLEGAL_TRAP_EN
    ,
    .illegal_op   (illegal_op)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sf, input logic nowb, input logic [3:0] rd);
    in_valid     = 1'b1;
    in_alu_ctrl  = code;
    in_a         = a;
    in_b         = b;
    in_set_flags = sf;
    in_no_wb     = nowb;
    in_rd        = rd;
  endtask

  typedef struct {
    logic [3:0]   code;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sf;
    logic [W-1:0] res;
    logic [3:0]   flg;
  } vec_t;

  vec_t logic_vecs[4];

  initial begin
    logic_vecs[0] = '{4'b1000, 32'h0000_00F0, 32'h0000_000F, 1'b0, 32'h0000_00FF, 4'b0001};
    logic_vecs[1] = '{4'b1001, 32'h0000_00FF, 32'h0000_000F, 1'b0, 32'h0000_00F0, 4'b0001};
    logic_vecs[2] = '{4'b1010, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0, 32'h0000_1234, 4'b0001};
    logic_vecs[3] = '{4'b1011, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 4'b1001};

    rst = 1'b1; in_valid = 1'b0; in_alu_ctrl = '0; in_a = '0; in_b = '0;
    in_set_flags = 1'b0; in_no_wb = 1'b0; in_rd = '0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_flags", flags, 4'b0000);
    chk("rst_out_result", out_result, 32'h0);
    rst = 1'b0; #1;
    chk("post_rst_in_ready", in_ready, 1'b1);

    // ADD wrap to zero: Z and C set.
    drive(4'b0000, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0, 4'd3);
    tick(); in_valid = 1'b0;
    chk("add_valid", out_valid, 1'b1);
    chk("add_result", out_result, 32'h0);
    chk("add_rd", out_rd, 4'd3);
    chk("add_wb_en", out_wb_en, 1'b1);
    chk("add_flags", flags, 4'b0110);
    out_ready = 1'b1; tick();
    chk("add_drained", out_valid, 1'b0);

    // SUB overflow, then AND retaining C/V while draining in the same cycle.
    drive(4'b0001, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'd1);
    tick();
    chk("sub_result", out_result, 32'h8000_0000);
    chk("sub_flags", flags, 4'b1001);
    drive(4'b0111, 32'h0000_F0F0, 32'h0000_0FF0, 1'b1, 1'b0, 4'd2);
    tick(); in_valid = 1'b0;
    chk("and_result", out_result, 32'h0000_00F0);
    chk("and_rd", out_rd, 4'd2);
    chk("and_flags", flags, 4'b0001);
    tick();
    chk("and_drained", out_valid, 1'b0);

    // Backpressure: fill both entries, then drain in order.
    out_ready = 1'b0;
    drive(4'b0000, 32'd1, 32'd1, 1'b0, 1'b0, 4'd4);
    tick();
    chk("bp1_in_ready", in_ready, 1'b1);
    chk("bp1_result", out_result, 32'd2);
    drive(4'b0000, 32'd2, 32'd2, 1'b0, 1'b0, 4'd5);
    tick();
    chk("bp2_in_ready", in_ready, 1'b0);
    chk("bp2_hold_result", out_result, 32'd2);
    drive(4'b0000, 32'd3, 32'd3, 1'b0, 1'b0, 4'd6);
    tick();
    chk("bp3_in_ready", in_ready, 1'b0);
    chk("bp3_hold_result", out_result, 32'd2);
    chk("bp3_hold_rd", out_rd, 4'd4);
    out_ready = 1'b1;
    tick();
    chk("bp_drain_r4", out_result, 32'd4);
    chk("bp_drain_rd5", out_rd, 4'd5);
    chk("bp_ready_back", in_ready, 1'b1);
    tick(); in_valid = 1'b0;
    chk("bp_drain_r6", out_result, 32'd6);
    chk("bp_drain_valid", out_valid, 1'b1);
    tick();
    chk("bp_empty", out_valid, 1'b0);
    chk("bp_flags_kept", flags, 4'b0001);

    // Streaming: one result per cycle, no bubble.
    for (int i = 0; i < 5; i++) begin
      drive(4'b0000, W'(i), 32'd10, 1'b0, 1'b0, 4'(i));
      tick();
      chk("stream_in_ready", in_ready, 1'b1);
      chk("stream_valid", out_valid, 1'b1);
      chk("stream_result", out_result, 64'(i + 10));
    end

    // Logic/move ops streamed; MVN sets N and keeps C/V.
    for (int i = 0; i < 4; i++) begin
      drive(logic_vecs[i].code, logic_vecs[i].a, logic_vecs[i].b, logic_vecs[i].sf, 1'b0, 4'd9);
      tick();
      chk("logic_result", out_result, logic_vecs[i].res);
      chk("logic_flags", flags, logic_vecs[i].flg);
    end
    in_valid = 1'b0;
    tick();
    chk("logic_drained", out_valid, 1'b0);

    // CMP-style SUB: no writeback, Z and C set.
    drive(4'b0001, 32'd5, 32'd5, 1'b1, 1'b1, 4'd7);
    tick(); in_valid = 1'b0;
    chk("cmp_result", out_result, 32'h0);
    chk("cmp_wb_en", out_wb_en, 1'b0);
    chk("cmp_flags", flags, 4'b0110);
    tick();

    // Unsupported code: result 0, no writeback, flags untouched.
    drive(4'b0011, 32'd9, 32'd9, 1'b1, 1'b0, 4'd5);
    tick(); in_valid = 1'b0;
    chk("ill_valid", out_valid, 1'b1);
    chk("ill_result", out_result, 32'h0);
    chk("ill_wb_en", out_wb_en, 1'b0);
    chk("ill_flags", flags, 4'b0110);
`ifdef ALU_EXEC_ILLEGAL_TRAP_EN
    chk("ill_trap", illegal_op, 1'b1);
    chk("ill_trap_ready", in_ready, 1'b0);
`else
    chk("ill_ready", in_ready, 1'b1);
`endif
    tick();
    chk("ill_drained", out_valid, 1'b0);
`ifdef ALU_EXEC_ILLEGAL_TRAP_EN
    chk("ill_trap_sticky", in_ready, 1'b0);
`endif

    // Reset with the buffer full.
    out_ready = 1'b0;
    drive(4'b0000, 32'd1, 32'd2, 1'b1, 1'b0, 4'd1);
    tick();
    drive(4'b0000, 32'd3, 32'd4, 1'b1, 1'b0, 4'd2);
    tick(); in_valid = 1'b0;
    chk("pre_rst_in_ready", in_ready, 1'b0);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_flags", flags, 4'b0000);
    chk("mid_rst_in_ready", in_ready, 1'b0);
    chk("mid_rst_result", out_result, 32'h0);
    chk("mid_rst_rd", out_rd, 4'd0);
    chk("mid_rst_wb_en", out_wb_en, 1'b0);
`ifdef ALU_EXEC_ILLEGAL_TRAP_EN
    chk("mid_rst_trap", illegal_op, 1'b0);
`endif
    rst = 1'b0; out_ready = 1'b1; #1;
    chk("rel_in_ready", in_ready, 1'b1);
    chk("rel_valid", out_valid, 1'b0);
    drive(4'b0000, 32'd7, 32'd8, 1'b0, 1'b0, 4'd2);
    tick(); in_valid = 1'b0;
    chk("fresh_result", out_result, 32'd15);
    chk("fresh_rd", out_rd, 4'd2);
    tick();
    chk("fresh_no_stale", out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
